// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for a regfile write port, with locked bursts of up to MAX_BURST beats.
// Latency: a beat accepted in cycle t appears on wr_en/wr_addr/wr_data in cycle t+1.
// Backpressure: req_ready is a one-hot-or-zero grant, and LOCKED admits only the owner. REGFILE_WRITE_ARBITER_STATS_EN adds counters.
module regfile_write_arbiter #(
    parameter int N         = 4,
    parameter int ADDR_W    = 2,
    parameter int DATA_W    = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                   CLK,
    input  logic                   ASYNCRESET,
    input  logic [N-1:0]           req_valid,
    input  logic [N-1:0]           req_last,
    input  logic [N*ADDR_W-1:0]    req_addr,
    input  logic [N*DATA_W-1:0]    req_data,
    output logic [N-1:0]           req_ready,
    output logic                   wr_en,
    output logic [ADDR_W-1:0]      wr_addr,
    output logic [DATA_W-1:0]      wr_data,
    output logic                   busy,
`ifdef REGFILE_WRITE_ARBITER_STATS_EN
    output logic [N*16-1:0]        grant_count,
    output logic                   forced_release,
`endif
    output logic [$clog2(N)-1:0]   owner
);
    localparam int IDX_W = $clog2(N);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t             state;
    logic [IDX_W-1:0]   rr_ptr;
    logic [CNT_W-1:0]   beat_cnt;
    logic [IDX_W-1:0]   win;
    logic [IDX_W-1:0]   scan;
    logic [IDX_W-1:0]   sel;
    logic               win_vld;
    logic               xfer;
    logic               sel_last;
    logic               at_limit;

    function automatic logic [IDX_W-1:0] inc_idx(input logic [IDX_W-1:0] i);
        return (i == IDX_W'(N - 1)) ? '0 : i + 1'b1;
    endfunction

    // First valid requester at or after rr_ptr, wrapping modulo N.
    always_comb begin
        win     = rr_ptr;
        win_vld = 1'b0;
        scan    = rr_ptr;
        for (int k = 0; k < N; k++) begin
            if (!win_vld && req_valid[scan]) begin
                win     = scan;
                win_vld = 1'b1;
            end
            scan = inc_idx(scan);
        end
    end

    always_comb begin
        req_ready = '0;
        if (ASYNCRESET) begin
            if (state == IDLE) begin
                if (win_vld)
                    req_ready[win] = 1'b1;
            end else begin
                req_ready[owner] = req_valid[owner];
            end
        end
    end

    assign sel      = (state == LOCKED) ? owner : win;
    assign xfer     = |(req_valid & req_ready);
    assign sel_last = req_last[sel];
    assign at_limit = (state == LOCKED) ? (beat_cnt == CNT_W'(MAX_BURST - 1)) : (MAX_BURST == 1);

    always_ff @(posedge CLK or negedge ASYNCRESET) begin
        if (!ASYNCRESET) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            owner    <= '0;
            beat_cnt <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            busy     <= 1'b0;
        end else begin
            wr_en <= xfer;
            if (xfer) begin
                wr_addr <= req_addr[sel*ADDR_W +: ADDR_W];
                wr_data <= req_data[sel*DATA_W +: DATA_W];
            end
            case (state)
                IDLE: begin
                    if (xfer) begin
                        owner <= win;
                        if (sel_last || at_limit) begin
                            rr_ptr <= inc_idx(win);
                        end else begin
                            state    <= LOCKED;
                            busy     <= 1'b1;
                            beat_cnt <= CNT_W'(1);
                        end
                    end
                end
                LOCKED: begin
                    if (xfer) begin
                        if (sel_last || at_limit) begin
                            state    <= IDLE;
                            busy     <= 1'b0;
                            rr_ptr   <= inc_idx(owner);
                            beat_cnt <= '0;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef REGFILE_WRITE_ARBITER_STATS_EN
    always_ff @(posedge CLK or negedge ASYNCRESET) begin
        if (!ASYNCRESET) begin
            grant_count    <= '0;
            forced_release <= 1'b0;
        end else begin
            forced_release <= xfer && !sel_last && at_limit;
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && req_ready[i] && (grant_count[i*16 +: 16] != 16'hFFFF))
                    grant_count[i*16 +: 16] <= grant_count[i*16 +: 16] + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter (N=4, ADDR_W=2, DATA_W=4, MAX_BURST=4).
module tb_regfile_write_arbiter;
    logic        CLK;
    logic        ASYNCRESET;
    logic [3:0]  req_valid;
    logic [3:0]  req_last;
    logic [7:0]  req_addr;
    logic [15:0] req_data;
    logic [3:0]  req_ready;
    logic        wr_en;
    logic [1:0]  wr_addr;
    logic [3:0]  wr_data;
    logic        busy;
    logic [1:0]  owner;
`ifdef REGFILE_WRITE_ARBITER_STATS_EN
    logic [63:0] grant_count;
    logic        forced_release;
`endif

    int          n_checks = 0;
    int          n_fail   = 0;
    logic        exp_we;
    logic [1:0]  exp_wa;
    logic [3:0]  exp_wd;

    regfile_write_arbiter #(.N(4), .ADDR_W(2), .DATA_W(4), .MAX_BURST(4)) dut (
        .CLK            (CLK),
        .ASYNCRESET     (ASYNCRESET),
        .req_valid      (req_valid),
        .req_last       (req_last),
        .req_addr       (req_addr),
        .req_data       (req_data),
        .req_ready      (req_ready),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .busy           (busy),
`ifdef REGFILE_WRITE_ARBITER_STATS_EN
        .grant_count    (grant_count),
        .forced_release (forced_release),
`endif
        .owner          (owner)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a falling edge: drive one cycle, check the grant and the write
    // produced by the previous cycle, then advance to the next falling edge.
    task automatic cyc(input string tag, input logic [3:0] v, input logic [3:0] l,
                       input logic [7:0] a, input logic [15:0] d,
                       input logic [3:0] exp_rdy, input logic exp_busy);
        req_valid = v;
        req_last  = l;
        req_addr  = a;
        req_data  = d;
        #1;
        check({tag, "_rdy"}, 32'(req_ready), 32'(exp_rdy));
        check({tag, "_busy"}, 32'(busy), 32'(exp_busy));
        check({tag, "_we"}, 32'(wr_en), 32'(exp_we));
        if (exp_we) begin
            check({tag, "_wa"}, 32'(wr_addr), 32'(exp_wa));
            check({tag, "_wd"}, 32'(wr_data), 32'(exp_wd));
        end
        exp_we = |(exp_rdy & v);
        for (int i = 0; i < 4; i++) begin
            if (exp_rdy[i]) begin
                exp_wa = a[i*2 +: 2];
                exp_wd = d[i*4 +: 4];
            end
        end
        @(negedge CLK);
    endtask

    initial begin
        exp_we     = 1'b0;
        exp_wa     = '0;
        exp_wd     = '0;
        ASYNCRESET = 1'b0;
        req_valid  = 4'hF;
        req_last   = 4'hF;
        req_addr   = 8'hE4;
        req_data   = 16'hDCBA;

        // Reset held with every requester valid.
        @(negedge CLK);
        @(negedge CLK);
        #1;
        check("rst_rdy", 32'(req_ready), 32'h0);
        check("rst_we", 32'(wr_en), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_owner", 32'(owner), 32'h0);
        check("rst_wa", 32'(wr_addr), 32'h0);
        check("rst_wd", 32'(wr_data), 32'h0);
        @(negedge CLK);
        ASYNCRESET = 1'b1;

        // Round-robin, single-beat requests from all four.
        for (int k = 0; k < 8; k++)
            cyc("rr", 4'hF, 4'hF, 8'hE4, 16'hDCBA, 4'(1 << (k % 4)), 1'b0);

        // Move the pointer to requester 2, then a 3-beat burst from 2 with 1 waiting.
        cyc("prep", 4'b0010, 4'b0010, 8'hE4, 16'hDCBA, 4'b0010, 1'b0);
        cyc("b1",   4'b0110, 4'b0000, 8'h10, 16'h0A00, 4'b0100, 1'b0);
        cyc("b2",   4'b0110, 4'b0000, 8'h20, 16'h0B00, 4'b0100, 1'b1);
        cyc("b3",   4'b0110, 4'b0100, 8'h30, 16'h0C00, 4'b0100, 1'b1);
        cyc("bnxt", 4'b1010, 4'b1010, 8'hE4, 16'hDCBA, 4'b1000, 1'b0);

        // Requester 0 never asserts last: release forced after beat 4.
        cyc("f1", 4'b0011, 4'b0000, 8'hE4, 16'hDCBA, 4'b0001, 1'b0);
        cyc("f2", 4'b0011, 4'b0000, 8'hE4, 16'hDCBA, 4'b0001, 1'b1);
        cyc("f3", 4'b0011, 4'b0000, 8'hE4, 16'hDCBA, 4'b0001, 1'b1);
        cyc("f4", 4'b0011, 4'b0000, 8'hE4, 16'hDCBA, 4'b0001, 1'b1);
`ifdef REGFILE_WRITE_ARBITER_STATS_EN
        check("f_pulse", 32'(forced_release), 32'h1);
`endif
        cyc("f5", 4'b0011, 4'b0010, 8'hE4, 16'hDCBA, 4'b0010, 1'b0);
        check("f_owner", 32'(owner), 32'h1);
`ifdef REGFILE_WRITE_ARBITER_STATS_EN
        check("f_pulse_end", 32'(forced_release), 32'h0);
`endif

        // Burst from 2 with a two-cycle bubble; 3 stays blocked, release after 4 real beats.
        cyc("u1", 4'b1100, 4'b0000, 8'hE4, 16'h0100, 4'b0100, 1'b0);
        cyc("u2", 4'b1100, 4'b0000, 8'hE4, 16'h0200, 4'b0100, 1'b1);
        cyc("u3", 4'b1000, 4'b0000, 8'hE4, 16'h0F00, 4'b0000, 1'b1);
        cyc("u4", 4'b1000, 4'b0000, 8'hE4, 16'h0F00, 4'b0000, 1'b1);
        cyc("u5", 4'b1100, 4'b0000, 8'hE4, 16'h0500, 4'b0100, 1'b1);
        cyc("u6", 4'b1100, 4'b0000, 8'hE4, 16'h0600, 4'b0100, 1'b1);
`ifdef REGFILE_WRITE_ARBITER_STATS_EN
        check("u_pulse", 32'(forced_release), 32'h1);
`endif
        cyc("u7", 4'b1000, 4'b1000, 8'hE4, 16'h0600, 4'b1000, 1'b0);
`ifdef REGFILE_WRITE_ARBITER_STATS_EN
        check("cnt_r0", 32'(grant_count[15:0]), 32'd6);
        check("cnt_r2", 32'(grant_count[47:32]), 32'd9);
`endif

        // Reset asserted during beat 2 of a burst from requester 3.
        cyc("m1", 4'b1000, 4'b0000, 8'hC0, 16'h7000, 4'b1000, 1'b0);
        req_valid = 4'b1000;
        req_last  = 4'b0000;
        req_addr  = 8'h40;
        req_data  = 16'h8000;
        #1;
        check("m2_rdy", 32'(req_ready), 32'h8);
        check("m2_busy", 32'(busy), 32'h1);
        check("m2_we", 32'(wr_en), 32'h1);
        check("m2_wa", 32'(wr_addr), 32'h3);
        check("m2_wd", 32'(wr_data), 32'h7);
        ASYNCRESET = 1'b0;
        #1;
        check("mr_we", 32'(wr_en), 32'h0);
        check("mr_busy", 32'(busy), 32'h0);
        check("mr_rdy", 32'(req_ready), 32'h0);
        check("mr_owner", 32'(owner), 32'h0);
`ifdef REGFILE_WRITE_ARBITER_STATS_EN
        check("mr_cnt", 32'(grant_count[63:32] | grant_count[31:0]), 32'h0);
`endif
        @(negedge CLK);
        ASYNCRESET = 1'b1;
        exp_we     = 1'b0;
        cyc("post",  4'b1001, 4'b1001, 8'hE4, 16'hDCBA, 4'b0001, 1'b0);
        cyc("post2", 4'b0000, 4'b0000, 8'hE4, 16'hDCBA, 4'b0000, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
